athena_hiscore_bridge: RTL
==========================

# athena_hiscore_bridge

Moves hiscore data between the Pocket bridge and the Athena CPU work RAM. The bridge writes 32-bit big-endian words into hiscore data slot 2, mapped at 0x1000fe50–0x1000fec1 (0x72 bytes). This block buffers those words and serialises them into byte writes on the CPU-RAM side port at 0xfe50. Bridge reads of the same range are gathered back from RAM into 32-bit words for hiscore save.

## Interface
Parameters:
- START, 32'h1000fe50, first bridge byte address of the hiscore region (word aligned).
- SIZE, 32'h72, region length in bytes.
- FIFO_DEPTH, 4, write-word buffer depth (power of 2).

Ports:
- clk  in  1  system clock; the only clock. Bridge signals are already synchronous to it.
- reset_n  in  1  asynchronous, active-low reset.
- bridge_wr  in  1  one-cycle write strobe.
- bridge_rd  in  1  one-cycle read strobe.
- bridge_addr  in  32  byte address, word aligned.
- bridge_wr_data  in  32  write word; byte at addr+0 is bits [31:24].
- bridge_rd_data  out  32  read word, same byte order; holds its value until the next read completes.
- bridge_rd_valid  out  1  one-cycle pulse; bridge_rd_data is valid in that cycle.
- busy  out  1  high while the FIFO is non-empty, a read is pending, or the FSM is not IDLE.
- overflow  out  1  sticky: a write was dropped because the FIFO was full.
- rd_collision  out  1  sticky: a bridge_rd arrived while a read was already pending.
- ram_req  out  1  RAM access request; held until ram_ack.
- ram_we  out  1  1 = write, 0 = read; stable while ram_req is high.
- ram_addr  out  7  byte offset 0x00–0x71 from 0xfe50.
- ram_wdata  out  8  write byte.
- ram_rdata  in  8  read byte; valid in the cycle ram_ack is high.
- ram_ack  in  1  access complete; may arrive in the same cycle ram_req rises or any later cycle.

## Operation
- In range: bridge_addr - START < SIZE (unsigned 32-bit). Strobes outside the range are ignored: nothing is enqueued and no read response is produced.
- Write path: an in-range bridge_wr pushes {offset[6:0], data[31:0]} into the FIFO.
  - If the FIFO is full, the word is dropped and overflow is set.
- FSM states: IDLE, WR_BYTE, RD_BYTE, RD_DONE.
- IDLE: if the FIFO is non-empty, pop it and go to WR_BYTE with byte index 0. Otherwise, if a read is pending, go to RD_BYTE with byte index 0. Writes take priority, so a read never overtakes earlier writes.
- WR_BYTE: drive ram_req=1, ram_we=1, ram_addr=offset+idx, ram_wdata=byte idx.
  - On ram_ack, increment idx.
  - Leave for IDLE after idx 3, or after the byte at offset 0x71.
  - Bytes at offsets ≥ SIZE (0x72, 0x73 of the last word) are never issued.
- Read request: an in-range bridge_rd latches its offset and sets the read-pending flag.
  - If a read is already pending, the new strobe is ignored and rd_collision is set.
- RD_BYTE: drive ram_req=1, ram_we=0. On ram_ack, capture ram_rdata into byte idx of an assembly register.
  - Bytes beyond SIZE are not read and assemble as 8'h00.
  - After the last byte, go to RD_DONE.
- RD_DONE: load bridge_rd_data, pulse bridge_rd_valid, clear the read-pending flag, return to IDLE.
- Simultaneous bridge_wr and bridge_rd in one cycle: the write is enqueued and the read is latched; the write completes in RAM before any read byte is issued.
- FIFO push and pop in the same cycle are legal; the occupancy count is unchanged.

## Timing
- Reset values:
  - ram_req, ram_we, bridge_rd_valid, busy, overflow, rd_collision = 0.
  - ram_addr = 0, ram_wdata = 0, bridge_rd_data = 0.
  - FSM = IDLE; FIFO empty; read-pending flag clear.
- Reset asserted mid-operation aborts the access immediately: ram_req drops asynchronously and all queued words and pending reads are discarded.
- Write latency: bridge_wr in cycle N with the FSM IDLE and FIFO empty → ram_req high in N+2 (push N, pop N+1, request N+2).
- Inter-byte spacing: the next byte's ram_addr/ram_wdata are presented in the cycle after ram_ack, with ram_req staying high.
  - With ram_ack tied high, a full word therefore takes 4 consecutive request cycles.
- Read latency with ram_ack tied high and the FSM idle: bridge_rd in N → req N+1..N+4 → bridge_rd_valid in N+6.
- The bridge_rd_valid pulse is exactly one cycle wide. busy falls in the cycle after the last access completes.

## Test plan
- Single write: wr addr 0x1000fe50, data 0x11223344, ack tied 1 → RAM writes 0x11@0x00, 0x22@0x01, 0x33@0x02, 0x44@0x03 in 4 consecutive cycles starting N+2.
- Tail clip: wr addr 0x1000fec0, data 0xAABBCCDD → only 0xAA@0x70 and 0xBB@0x71 are written. A read of the same address then returns 0xAABB0000.
- Overflow with ram_ack held low: 5 back-to-back writes → the 5th is dropped and overflow=1. Releasing ack drains exactly 4 words, 16 bytes, in order.
- Ordering: wr and rd of 0x1000fe60 in the same cycle, data 0xDEADBEEF → all 4 write acks precede the first read request, and bridge_rd_data = 0xDEADBEEF.
- Out of range and collision:
  - wr/rd at 0x1000fe4c and 0x1000fec4 → no ram_req and no valid pulse.
  - A second rd while the first is pending (ack low) → rd_collision=1 and only one valid pulse.
- Reset mid-word: assert reset_n=0 during the 2nd byte → ram_req drops the same cycle. After release, busy=0 and no further RAM traffic.

Source files
------------

// File: rtl/athena_hiscore_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : athena_hiscore_bridge
//  Purpose  : Moves hiscore data between the Pocket bridge and the Athena CPU
//             work RAM. In-range 32-bit bridge writes are buffered and sent to
//             RAM as byte writes. In-range bridge reads are gathered back from
//             RAM into 32-bit big-endian words.
//  Ports    : clk, reset_n            - clock, async active-low reset
//             bridge_wr/rd            - one-cycle write / read strobes
//             bridge_addr             - byte address (word aligned)
//             bridge_wr_data          - write word, addr+0 in [31:24]
//             bridge_rd_data/_valid   - read word and one-cycle valid pulse
//             busy, overflow,
//             rd_collision            - status (overflow/collision sticky)
//             ram_req/we/addr/wdata   - CPU-RAM byte access request
//             ram_rdata, ram_ack      - CPU-RAM read byte and completion
//  Revision : 1.0 - initial release
// ============================================================================
module athena_hiscore_bridge #(
   parameter logic [31:0] START      = 32'h1000fe50,
   parameter logic [31:0] SIZE       = 32'h72,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        bridge_wr,
   input  logic        bridge_rd,
   input  logic [31:0] bridge_addr,
   input  logic [31:0] bridge_wr_data,
   output logic [31:0] bridge_rd_data,
   output logic        bridge_rd_valid,
   output logic        busy,
   output logic        overflow,
   output logic        rd_collision,
   output logic        ram_req,
   output logic        ram_we,
   output logic [6:0]  ram_addr,
   output logic [7:0]  ram_wdata,
   input  logic [7:0]  ram_rdata,
   input  logic        ram_ack
);

   // FIFO_DEPTH must be a power of two, at least 2, so pointers wrap freely.
   localparam int               c_PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [c_PTR_W:0] c_DEPTH    = FIFO_DEPTH[c_PTR_W:0];
   localparam logic [c_PTR_W:0] c_CNT_ONE  = 1;
   localparam logic [c_PTR_W-1:0] c_PTR_ONE = 1;
   localparam logic [6:0]       c_LAST_OFF = 7'(SIZE - 32'd1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR_BYTE = 2'd1,
      RD_BYTE = 2'd2,
      RD_DONE = 2'd3
   } state_t;

   // ------------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------------
   logic [31:0] w_off;
   logic        w_in_range;

   assign w_off      = bridge_addr - START;
   assign w_in_range = (w_off < SIZE);

   // ------------------------------------------------------------------------
   // Write-word FIFO: entry = {offset[6:0], data[31:0]}
   // ------------------------------------------------------------------------
   logic [38:0]        mem_q [FIFO_DEPTH];
   logic [c_PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [c_PTR_W:0]   count_q;
   logic               w_full, w_empty, w_push, w_pop;
   logic [38:0]        w_head;

   assign w_full  = (count_q == c_DEPTH);
   assign w_empty = (count_q == '0);
   assign w_push  = bridge_wr & w_in_range & ~w_full;
   assign w_head  = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= {w_off[6:0], bridge_wr_data};
      end
   end

   // The head entry is copied into the byte engine in IDLE but only released
   // when its last byte is acknowledged, so the word being written still
   // occupies a FIFO slot and the depth bounds all unfinished words.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_push) wr_ptr_q <= wr_ptr_q + c_PTR_ONE;
         if (w_pop)  rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   count_q <= count_q + c_CNT_ONE;
            2'b01:   count_q <= count_q - c_CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Read request tracking
   // ------------------------------------------------------------------------
   logic       rd_pend_q;
   logic [6:0] rd_off_q;
   logic       w_rd_accept, w_rd_collide, w_rd_done;

   assign w_rd_accept  = bridge_rd & w_in_range & ~rd_pend_q;
   assign w_rd_collide = bridge_rd & w_in_range &  rd_pend_q;

   // ------------------------------------------------------------------------
   // Byte engine FSM
   // ------------------------------------------------------------------------
   state_t      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [6:0]  off_q, off_d;
   logic [31:0] data_q, data_d;
   logic [31:0] asm_q, asm_d;
   logic [6:0]  w_byte_off;
   logic [4:0]  w_lane;
   logic        w_last;

   assign w_byte_off = off_q + {5'd0, idx_q};
   // Byte idx 0 is the most significant byte of the word.
   assign w_lane     = {~idx_q, 3'b000};
   // A word stops after its 4th byte or at the last byte of the region.
   assign w_last     = (idx_q == 2'd3) || (w_byte_off == c_LAST_OFF);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      off_d     = off_q;
      data_d    = data_q;
      asm_d     = asm_q;
      w_pop     = 1'b0;
      w_rd_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (!w_empty) begin
               state_d = WR_BYTE;
               idx_d   = 2'd0;
               off_d   = w_head[38:32];
               data_d  = w_head[31:0];
            end else if (!w_push && (rd_pend_q || w_rd_accept)) begin
               // A read may launch straight from its strobe, but never in a
               // cycle that also enqueues a write, so writes stay ahead.
               state_d = RD_BYTE;
               idx_d   = 2'd0;
               off_d   = rd_pend_q ? rd_off_q : w_off[6:0];
               asm_d   = 32'd0;
            end
         end
         WR_BYTE: begin
            if (ram_ack) begin
               if (w_last) begin
                  state_d = IDLE;
                  w_pop   = 1'b1;
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end
         end
         RD_BYTE: begin
            if (ram_ack) begin
               asm_d[w_lane +: 8] = ram_rdata;
               if (w_last) begin
                  state_d = RD_DONE;
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end
         end
         RD_DONE: begin
            w_rd_done = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   logic [31:0] rd_data_q;
   logic        rd_valid_q;
   logic        overflow_q;
   logic        collision_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         idx_q       <= 2'd0;
         off_q       <= 7'd0;
         data_q      <= 32'd0;
         asm_q       <= 32'd0;
         rd_pend_q   <= 1'b0;
         rd_off_q    <= 7'd0;
         rd_data_q   <= 32'd0;
         rd_valid_q  <= 1'b0;
         overflow_q  <= 1'b0;
         collision_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         off_q      <= off_d;
         data_q     <= data_d;
         asm_q      <= asm_d;
         rd_valid_q <= w_rd_done;
         if (w_rd_done) begin
            rd_data_q <= asm_q;
            rd_pend_q <= 1'b0;
         end else if (w_rd_accept) begin
            rd_pend_q <= 1'b1;
         end
         if (w_rd_accept) rd_off_q <= w_off[6:0];
         if (bridge_wr && w_in_range && w_full) overflow_q <= 1'b1;
         if (w_rd_collide) collision_q <= 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs. ram_req decodes the state register directly, so an
   // asynchronous reset withdraws it immediately.
   // ------------------------------------------------------------------------
   assign ram_req         = (state_q == WR_BYTE) || (state_q == RD_BYTE);
   assign ram_we          = (state_q == WR_BYTE);
   assign ram_addr        = w_byte_off;
   assign ram_wdata       = data_q[w_lane +: 8];
   assign bridge_rd_data  = rd_data_q;
   assign bridge_rd_valid = rd_valid_q;
   assign overflow        = overflow_q;
   assign rd_collision    = collision_q;
   assign busy            = !w_empty || rd_pend_q || (state_q != IDLE);

endmodule
`default_nettype wire
